// File: rtl/pdcch_stream_router.sv
// PDCCH stream router: parses a header word, gathers config words onto a flat bus,
// then forwards a counted payload to one of NUM_CH output channels.
//
// state   | meaning
// IDLE    | waiting for a header word
// CFG     | collecting cfg_len config words into cfg_out
// CFG_OUT | presenting cfg_out until the consumer accepts it
// DATA    | forwarding data_len payload words to the addressed channel
// DROP    | swallowing the words of an oversized packet
module pdcch_stream_router #(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_CFG_WORDS = 8,
  parameter int LEN_W         = 10,
  parameter int NUM_CH        = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [MAX_CFG_WORDS*DATA_WIDTH-1:0] cfg_out,
  output logic                                cfg_valid,
  input  logic                                cfg_ready,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                data_last,
  output logic [NUM_CH-1:0]                   data_valid,
  input  logic [NUM_CH-1:0]                   data_ready,
  output logic                                pkt_done,
  output logic                                err_oversize
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LEN_W:0] ONE     = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] MAX_CFG = (LEN_W+1)'(MAX_CFG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_CFG_OUT,
    S_DATA,
    S_DROP
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cfg_len_q;
  logic [LEN_W-1:0] data_len_q;
  logic [CH_W-1:0]  ch_q;
  logic [LEN_W:0]   cnt;
  logic [LEN_W:0]   drop_len;

  logic [LEN_W-1:0] hdr_cfg_len;
  logic [LEN_W-1:0] hdr_data_len;
  logic [CH_W-1:0]  hdr_ch_raw;
  logic [CH_W-1:0]  hdr_ch;
  logic             hdr_oversize;
  logic             xfer;
  logic             drain;
  logic [LEN_W:0]   cfg_last_idx;
  logic [LEN_W:0]   data_last_idx;
  logic [LEN_W:0]   drop_last_idx;
  logic [NUM_CH-1:0] ch_onehot;

  assign hdr_cfg_len  = in_data[LEN_W-1:0];
  assign hdr_data_len = in_data[2*LEN_W-1:LEN_W];
  assign hdr_ch_raw   = in_data[2*LEN_W +: CH_W];
  assign hdr_oversize = {1'b0, hdr_cfg_len} > MAX_CFG;

  // Channel codes beyond the last real channel all land on the last channel.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_ch_pow2
      assign hdr_ch = hdr_ch_raw;
    end else begin : g_ch_clip
      assign hdr_ch = (hdr_ch_raw > CH_W'(NUM_CH-1)) ? CH_W'(NUM_CH-1) : hdr_ch_raw;
    end
  endgenerate

  assign xfer          = in_valid & in_ready;
  assign drain         = |(data_valid & data_ready);
  assign cfg_last_idx  = {1'b0, cfg_len_q} - ONE;
  assign data_last_idx = {1'b0, data_len_q} - ONE;
  assign drop_last_idx = drop_len - ONE;
  assign ch_onehot     = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_q;

  // The payload register is single-entry: accept only when empty or draining.
  always_comb begin
    in_ready = 1'b0;
    if (reset_n) begin
      case (state)
        S_IDLE:    in_ready = 1'b1;
        S_CFG:     in_ready = 1'b1;
        S_CFG_OUT: in_ready = 1'b0;
        S_DATA:    in_ready = ~(|data_valid) | drain;
        S_DROP:    in_ready = 1'b1;
        default:   in_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cfg_len_q    <= '0;
      data_len_q   <= '0;
      ch_q         <= '0;
      cnt          <= '0;
      drop_len     <= '0;
      cfg_out      <= '0;
      cfg_valid    <= 1'b0;
      data_out     <= '0;
      data_last    <= 1'b0;
      data_valid   <= '0;
      pkt_done     <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      pkt_done     <= 1'b0;
      err_oversize <= 1'b0;

      // A held payload word may drain in any state; a new load below overrides.
      if (drain) begin
        data_valid <= '0;
        data_last  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (xfer) begin
            cfg_len_q  <= hdr_cfg_len;
            data_len_q <= hdr_data_len;
            ch_q       <= hdr_ch;
            cnt        <= '0;
            cfg_out    <= '0;
            drop_len   <= {1'b0, hdr_cfg_len} + {1'b0, hdr_data_len};
            if (hdr_oversize) begin
              state        <= S_DROP;
              err_oversize <= 1'b1;
            end else if (hdr_cfg_len != '0) begin
              state <= S_CFG;
            end else if (hdr_data_len != '0) begin
              state <= S_DATA;
            end else begin
              pkt_done <= 1'b1;
            end
          end
        end

        S_CFG: begin
          if (xfer) begin
            for (int k = 0; k < MAX_CFG_WORDS; k++) begin
              if (cnt == (LEN_W+1)'(k)) begin
                cfg_out[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
              end
            end
            if (cnt == cfg_last_idx) begin
              state     <= S_CFG_OUT;
              cfg_valid <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end

        S_CFG_OUT: begin
          if (cfg_ready) begin
            cfg_valid <= 1'b0;
            if (data_len_q != '0) begin
              state <= S_DATA;
            end else begin
              state    <= S_IDLE;
              pkt_done <= 1'b1;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            data_out   <= in_data;
            data_valid <= ch_onehot;
            data_last  <= (cnt == data_last_idx);
            if (cnt == data_last_idx) begin
              state    <= S_IDLE;
              pkt_done <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end

        S_DROP: begin
          if (xfer) begin
            if (cnt == drop_last_idx) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
